// File: rtl/mod_fold_reduce_pkg.sv
// Shared types and helpers for the constant-modulus fold reducer.
package mod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    ADJ  = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Fold constant for M = 2^K - C.
  function automatic int calc_c(input int k, input int m);
    return (1 << k) - m;
  endfunction

endpackage

// File: rtl/mod_fold_reduce_fold_step.sv
// One fold of x -> (x >> K)*C + x[K-1:0]; purely combinational.
module fold_step #(
  parameter int XW = 32,
  parameter int K  = 8,
  parameter int C  = 77
) (
  input  logic [XW-1:0] acc_in,
  output logic [XW-1:0] acc_out,
  output logic          hi_zero
);

  logic [XW-K-1:0] hi;
  logic [K-1:0]    lo;
  logic [XW-1:0]   prod;

  assign hi      = acc_in[XW-1:K];
  assign lo      = acc_in[K-1:0];
  // Truncation to XW bits is exact: hi*C + lo stays below 2^(XW-1) + 2^K.
  assign prod    = XW'(hi) * XW'(C);
  assign acc_out = prod + XW'(lo);
  assign hi_zero = (hi == '0);

endmodule

// File: rtl/mod_fold_reduce.sv
// Iterative constant-modulus reducer z = x mod M with valid/ready on both sides.
//   state | meaning
//   IDLE  | waiting for x, in_ready high
//   FOLD  | one fold per cycle until acc < 2^K
//   ADJ   | single conditional subtract of M, capture z and fold count
//   HOLD  | present z until the consumer takes it
module mod_fold_reduce
  import mod_pkg::*;
#(
  parameter int XW = 32,
  parameter int K  = 8,
  parameter int M  = 179,
  parameter int IW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [K-1:0]  z,
  output logic [IW-1:0] folds,
  output logic          busy
);

  localparam int C = calc_c(K, M);

  if (XW < K + 2) begin : g_bad_xw
    $error("mod_fold_reduce: XW must be at least K+2");
  end
  if (!((M > (1 << (K - 1))) && (M < (1 << K)))) begin : g_bad_m
    $error("mod_fold_reduce: M must satisfy 2^(K-1) < M < 2^K");
  end
  if (IW < 1) begin : g_bad_iw
    $error("mod_fold_reduce: IW must be at least 1");
  end

  state_t        state;
  logic [XW-1:0] acc;
  logic [XW-1:0] acc_next;
  logic          hi_zero;
  logic [IW-1:0] cnt;
  logic [K-1:0]  z_sub;

  fold_step #(.XW(XW), .K(K), .C(C)) u_fold (
    .acc_in  (acc),
    .acc_out (acc_next),
    .hi_zero (hi_zero)
  );

  // acc < 2^K in ADJ, so the low K bits of acc-M are the whole difference.
  assign z_sub = acc[K-1:0] - K'(M);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      z         <= '0;
      folds     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc      <= x;
            cnt      <= '0;
            state    <= FOLD;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        FOLD: begin
          if (!hi_zero) begin
            acc <= acc_next;
            if (cnt != '1) cnt <= cnt + IW'(1);
          end else begin
            state <= ADJ;
          end
        end
        ADJ: begin
          z         <= (acc >= XW'(M)) ? z_sub : acc[K-1:0];
          folds     <= cnt;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
